// File: rtl/lsu_mem_responder.sv
// Single-outstanding LSU data-memory slave: byte-masked stores and raw LSB-aligned
// loads against a 64-bit word array, answered a fixed number of cycles after accept.
module lsu_mem_responder #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_mask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  counter_reg, counter_next;
    logic [63:0] addr_reg, addr_next;
    logic        wen_reg, wen_next;
    logic [63:0] wdata_reg, wdata_next;
    logic [7:0]  mask_reg, mask_next;
    logic [63:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;
    logic [63:0] rd_word_reg;

    logic [63:0] mem [0:DEPTH-1];

    logic          accept;
    logic          commit;
    logic [AW-1:0] req_idx;
    logic [63:0]   off;
    logic [AW-1:0] idx;
    logic [2:0]    b;
    logic [5:0]    sh;
    logic          range_err;
    logic          size_err;
    logic          align_err;
    logic          access_err;
    logic [7:0]    byte_en;
    logic [63:0]   lane_mask;
    logic [63:0]   load_data;
    logic [63:0]   store_data;

    // The word is fetched on the accept edge so the data is ready even at LATENCY=1;
    // nothing else can write the array while the request is in flight.
    assign req_idx = AW'((req_addr - BASE_ADDR) >> 3);
    assign accept  = (state_reg == IDLE) && req_valid && reset;

    assign off       = addr_reg - BASE_ADDR;
    assign idx       = off[3 +: AW];
    assign b         = addr_reg[2:0];
    assign sh        = {b, 3'b000};
    assign range_err = (off >= SPAN);

    always_comb begin
        size_err  = 1'b0;
        align_err = 1'b0;
        case (mask_reg)
            8'h01:   align_err = 1'b0;
            8'h03:   align_err = b[0];
            8'h0F:   align_err = |b[1:0];
            8'hFF:   align_err = |b;
            default: size_err  = 1'b1;
        endcase
    end

    assign access_err = range_err | size_err | align_err;
    assign byte_en    = mask_reg << b;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{mask_reg[gi]}};
        end
    endgenerate

    assign load_data  = (rd_word_reg >> sh) & lane_mask;
    assign store_data = wdata_reg << sh;

    // Reset on the commit edge wins, so an aborted store never lands.
    assign commit = (state_reg == BUSY) && (counter_reg == 4'd0) && wen_reg
                    && !access_err && reset;

    always_ff @(posedge clock) begin
        if (accept) begin
            rd_word_reg <= mem[req_idx];
        end
        if (commit) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        addr_next    = addr_reg;
        wen_next     = wen_reg;
        wdata_next   = wdata_reg;
        mask_next    = mask_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = reset;
                if (accept) begin
                    addr_next    = req_addr;
                    wen_next     = req_wen;
                    wdata_next   = req_wdata;
                    mask_next    = req_mask;
                    counter_next = CNT_INIT;
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (counter_reg == 4'd0) begin
                    err_next   = access_err;
                    rdata_next = (access_err || wen_reg) ? 64'd0 : load_data;
                    state_next = RESP;
                end else begin
                    counter_next = counter_reg - 4'd1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            counter_reg <= 4'd0;
            addr_reg    <= 64'd0;
            wen_reg     <= 1'b0;
            wdata_reg   <= 64'd0;
            mask_reg    <= 8'd0;
            rdata_reg   <= 64'd0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            addr_reg    <= addr_next;
            wen_reg     <= wen_next;
            wdata_reg   <= wdata_next;
            mask_reg    <= mask_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
        end
    end

    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: expected responses are queued on accept
// and compared on each response handshake, with latency and backpressure checks.
module tb_lsu_mem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = 64'd0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = 64'd0;
    logic [7:0]  req_mask = 8'hFF;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_err;

    lsu_mem_responder #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH),
        .LATENCY  (LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_wdata (req_wdata),
        .req_mask  (req_mask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_next;
    exp_t exp_cur;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;
    int accept_cyc   = 0;
    int hs_cyc       = 0;
    int accept_cnt   = 0;
    int resp_cnt     = 0;
    logic resp_valid_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clock) cycle <= cycle + 1;

    // Inputs are stable around the falling edge, so handshakes for the coming edge are seen here.
    always @(negedge clock) begin
        if (resp_valid && !resp_valid_prev) begin
            check("latency", 64'(cycle - accept_cyc - 1), 64'(LAT));
        end
        if (resp_valid && resp_ready) begin
            hs_cyc = cycle;
            check("pending", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) begin
                exp_cur = exp_q.pop_front();
                resp_cnt++;
                $display("[TB] resp %0d rdata=%h err=%0d (exp %h/%0d)",
                         resp_cnt, resp_rdata, resp_err, exp_cur.rdata, exp_cur.err);
                check("rdata", resp_rdata, exp_cur.rdata);
                check("err", 64'(resp_err), 64'(exp_cur.err));
            end
        end
        if (reset && req_valid && req_ready) begin
            accept_cyc = cycle;
            accept_cnt++;
            exp_q.push_back(exp_next);
        end
        resp_valid_prev = resp_valid;
    end

    task automatic send(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                        input logic [7:0] mask, input logic [63:0] exp_rdata, input logic exp_err);
        int start;
        int n;
        start           = accept_cnt;
        n               = 0;
        req_addr        = addr;
        req_wen         = wen;
        req_wdata       = wdata;
        req_mask        = mask;
        exp_next.rdata  = exp_rdata;
        exp_next.err    = exp_err;
        req_valid       = 1'b1;
        while (accept_cnt == start && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (accept_cnt == start) check("accept_timeout", 64'(n), 64'd0);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("resp_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic txn(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                       input logic [7:0] mask, input logic [63:0] exp_rdata, input logic exp_err);
        send(addr, wen, wdata, mask, exp_rdata, exp_err);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acc_before;

        // Reset held with a request offered: nothing may be accepted.
        req_valid = 1'b1;
        req_addr  = BASE;
        req_mask  = 8'hFF;
        repeat (3) begin
            @(negedge clock);
            check("rst_resp_valid", 64'(resp_valid), 64'd0);
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_rdata", resp_rdata, 64'd0);
            check("rst_err", 64'(resp_err), 64'd0);
        end
        check("rst_accepts", 64'(accept_cnt), 64'd0);
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Doubleword store/load, then byte store and sub-word loads.
        txn(BASE, 1'b1, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0);
        txn(BASE, 1'b0, 64'd0, 8'hFF, 64'h1122334455667788, 1'b0);
        txn(BASE + 64'd3, 1'b1, 64'h0000_0000_0000_00AB, 8'h01, 64'd0, 1'b0);
        txn(BASE, 1'b0, 64'd0, 8'hFF, 64'h11223344AB667788, 1'b0);
        txn(BASE + 64'd4, 1'b0, 64'd0, 8'h0F, 64'h0000_0000_1122_3344, 1'b0);
        txn(BASE + 64'd6, 1'b0, 64'd0, 8'h03, 64'h0000_0000_0000_1122, 1'b0);
        txn(BASE + 64'd3, 1'b0, 64'd0, 8'h01, 64'h0000_0000_0000_00AB, 1'b0);

        // Errors: misaligned, bad mask, below base, one past the end.
        txn(BASE + 64'd1, 1'b0, 64'd0, 8'h03, 64'd0, 1'b1);
        txn(BASE + 64'd2, 1'b1, 64'hFFFF_FFFF, 8'h0F, 64'd0, 1'b1);
        txn(BASE, 1'b0, 64'd0, 8'h07, 64'd0, 1'b1);
        txn(BASE + 64'h7FF8, 1'b1, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0);
        txn(64'h7FFF_FFF8, 1'b1, 64'hFFFF_FFFF, 8'h0F, 64'd0, 1'b1);
        txn(BASE + 64'h7FF8, 1'b0, 64'd0, 8'hFF, 64'h0123456789ABCDEF, 1'b0);
        txn(BASE + 64'(DEPTH * 8), 1'b1, 64'hFFFF_FFFF, 8'h0F, 64'd0, 1'b1);
        txn(BASE, 1'b0, 64'd0, 8'hFF, 64'h11223344AB667788, 1'b0);

        // Backpressure with a second request waiting.
        resp_ready = 1'b0;
        send(BASE, 1'b0, 64'd0, 8'hFF, 64'h11223344AB667788, 1'b0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!resp_valid) check("stall_resp_timeout", 64'(n), 64'd0);
        acc_before     = accept_cnt;
        req_addr       = BASE + 64'd8;
        req_wen        = 1'b1;
        req_wdata      = 64'h5555AAAA5555AAAA;
        req_mask       = 8'hFF;
        exp_next.rdata = 64'd0;
        exp_next.err   = 1'b0;
        req_valid      = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("stall_resp_valid", 64'(resp_valid), 64'd1);
            check("stall_rdata", resp_rdata, 64'h11223344AB667788);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        check("stall_no_accept", 64'(accept_cnt), 64'(acc_before));
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        n = 0;
        while (accept_cnt == acc_before && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        req_valid = 1'b0;
        check("second_accepted", 64'(accept_cnt), 64'(acc_before + 1));
        check("accept_gap", 64'(accept_cyc - hs_cyc), 64'd1);
        drain();
        txn(BASE + 64'd8, 1'b0, 64'd0, 8'hFF, 64'h5555AAAA5555AAAA, 1'b0);

        // Reset during BUSY drops the store.
        txn(BASE + 64'h10, 1'b1, 64'hCAFEF00D12345678, 8'hFF, 64'd0, 1'b0);
        send(BASE + 64'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("abort_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        txn(BASE + 64'h10, 1'b0, 64'd0, 8'hFF, 64'hCAFEF00D12345678, 1'b0);

        repeat (3) @(posedge clock);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
